// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the two-master MIPS memory bus arbiter.
// Build option: MIPS_BUS_ARB_RR_EN selects round-robin tie-breaking.
package mips_bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam logic [BUS_DW/8-1:0] BE_ALL = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } bus_op_t;

endpackage

// File: rtl/mips_bus_arb_pick.sv
// Grant decision between the fetch and data ports.
// MIPS_BUS_ARB_RR_EN: round-robin with a last-grant flop; otherwise data has fixed priority.
module mips_bus_arb_pick (
`ifdef MIPS_BUS_ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic i_grant_en,
`endif
    input  logic i_req_fetch,
    input  logic i_req_data,
    output logic o_pick_fetch,
    output logic o_pick_data
);

`ifdef MIPS_BUS_ARB_RR_EN
    logic r_last_d;

    // On a tie the port that did not win last time goes first.
    assign o_pick_data  = i_req_data & (~i_req_fetch | ~r_last_d);
    assign o_pick_fetch = i_req_fetch & ~o_pick_data;

    // Reset to "data won last" so fetch takes the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_d <= 1'b1;
        end else if (i_grant_en) begin
            r_last_d <= o_pick_data;
        end
    end
`else
    assign o_pick_data  = i_req_data;
    assign o_pick_fetch = i_req_fetch & ~i_req_data;
`endif

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-style memory bus between the instruction-fetch and load/store ports.
// Build option: MIPS_BUS_ARB_RR_EN (round-robin ties); default is data-port priority.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int AW = BUS_AW,
    parameter int DW = BUS_DW
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [AW-1:0]   i_address,
    input  logic            i_read,
    output logic            i_waitrequest,
    output logic [DW-1:0]   i_readdata,

    input  logic [AW-1:0]   d_address,
    input  logic            d_read,
    input  logic            d_write,
    input  logic [DW/8-1:0] d_byteenable,
    input  logic [DW-1:0]   d_writedata,
    output logic            d_waitrequest,
    output logic [DW-1:0]   d_readdata,

    output logic [AW-1:0]   m_address,
    output logic            m_read,
    output logic            m_write,
    output logic [DW/8-1:0] m_byteenable,
    output logic [DW-1:0]   m_writedata,
    input  logic            m_waitrequest,
    input  logic [DW-1:0]   m_readdata,

    output logic            grant_d
);

    arb_state_t        r_state;
    bus_op_t           r_op;
    logic              r_grant_d;
    logic [AW-1:0]     r_m_address;
    logic [DW/8-1:0]   r_m_byteenable;
    logic [DW-1:0]     r_m_writedata;
    logic              r_m_read;
    logic              r_m_write;
    logic              r_i_waitrequest;
    logic              r_d_waitrequest;
    logic [DW-1:0]     r_i_readdata;
    logic [DW-1:0]     r_d_readdata;

    logic              w_d_req;
    logic              w_pick_i;
    logic              w_pick_d;
    logic              w_any_grant;

    assign w_d_req     = d_read | d_write;
    assign w_any_grant = w_pick_i | w_pick_d;

`ifdef MIPS_BUS_ARB_RR_EN
    logic w_grant_en;
    assign w_grant_en = (r_state == IDLE) & w_any_grant;
`endif

    mips_bus_arb_pick u_pick (
`ifdef MIPS_BUS_ARB_RR_EN
        .clk          (clk),
        .reset        (reset),
        .i_grant_en   (w_grant_en),
`endif
        .i_req_fetch  (i_read),
        .i_req_data   (w_d_req),
        .o_pick_fetch (w_pick_i),
        .o_pick_data  (w_pick_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_op            <= OP_READ;
            r_grant_d       <= 1'b0;
            r_m_address     <= '0;
            r_m_byteenable  <= '0;
            r_m_writedata   <= '0;
            r_m_read        <= 1'b0;
            r_m_write       <= 1'b0;
            r_i_waitrequest <= 1'b1;
            r_d_waitrequest <= 1'b1;
            r_i_readdata    <= '0;
            r_d_readdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_grant) begin
                        r_state   <= ACCESS;
                        r_grant_d <= w_pick_d;
                        if (w_pick_d) begin
                            // A simultaneous read+write is treated as a write.
                            r_m_address    <= d_address;
                            r_m_byteenable <= d_byteenable;
                            r_m_writedata  <= d_writedata;
                            r_op           <= d_write ? OP_WRITE : OP_READ;
                            r_m_write      <= d_write;
                            r_m_read       <= ~d_write;
                        end else begin
                            r_m_address    <= i_address;
                            r_m_byteenable <= BE_ALL;
                            r_m_writedata  <= '0;
                            r_op           <= OP_READ;
                            r_m_write      <= 1'b0;
                            r_m_read       <= 1'b1;
                        end
                    end
                end

                ACCESS: begin
                    if (!m_waitrequest) begin
                        r_m_read  <= 1'b0;
                        r_m_write <= 1'b0;
                        if (r_op == OP_WRITE) begin
                            r_state <= DONE;
                            if (r_grant_d) begin
                                r_d_waitrequest <= 1'b0;
                            end else begin
                                r_i_waitrequest <= 1'b0;
                            end
                        end else begin
                            r_state <= RESP;
                        end
                    end
                end

                RESP: begin
                    r_state <= DONE;
                    if (r_grant_d) begin
                        r_d_readdata    <= m_readdata;
                        r_d_waitrequest <= 1'b0;
                    end else begin
                        r_i_readdata    <= m_readdata;
                        r_i_waitrequest <= 1'b0;
                    end
                end

                DONE: begin
                    r_state         <= IDLE;
                    r_i_waitrequest <= 1'b1;
                    r_d_waitrequest <= 1'b1;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_address     = r_m_address;
    assign m_read        = r_m_read;
    assign m_write       = r_m_write;
    assign m_byteenable  = r_m_byteenable;
    assign m_writedata   = r_m_writedata;
    assign i_waitrequest = r_i_waitrequest;
    assign d_waitrequest = r_d_waitrequest;
    assign i_readdata    = r_i_readdata;
    assign d_readdata    = r_d_readdata;
    assign grant_d       = r_grant_d;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: transaction-level timing model plus bus responder.
// Honours MIPS_BUS_ARB_RR_EN when predicting tie winners.
module tb_mips_bus_arbiter;

`ifdef MIPS_BUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_byteenable;
    logic [31:0] d_writedata;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        grant_d;

    mips_bus_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .i_address     (i_address),
        .i_read        (i_read),
        .i_waitrequest (i_waitrequest),
        .i_readdata    (i_readdata),
        .d_address     (d_address),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_byteenable  (d_byteenable),
        .d_writedata   (d_writedata),
        .d_waitrequest (d_waitrequest),
        .d_readdata    (d_readdata),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_byteenable  (m_byteenable),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .grant_d       (grant_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int          gap;
        bit          wr;
        bit          both;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          stall;
        logic [31:0] rdata;
    } txn_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ntxn = 0;

    txn_t fq[$];
    txn_t dq[$];
    bit   f_has, d_has;
    int   f_gap, d_gap;

    // Model of the transaction currently owning the bus
    bit          active, a_own_d, a_wr, last_d;
    int          t_arb, a_stall, done_cyc, free_from;
    logic [31:0] a_rdata;
    logic [31:0] sh_addr, sh_wd, exp_ird, exp_drd;
    logic [3:0]  sh_be;
    bit          sh_grant_d;

    bit dut_win[$];
    int f_raise, d_raise, i_done_obs, d_done_obs;
    int mread_seen, mwrite_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    function automatic txn_t mk(input int gap, input bit wr, input bit both, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wd, input int stall,
                                input logic [31:0] rdata);
        txn_t t;
        t.gap = gap; t.wr = wr; t.both = both; t.addr = addr;
        t.be = be; t.wd = wd; t.stall = stall; t.rdata = rdata;
        return t;
    endfunction

    task automatic drive_ports();
        i_read = f_has;
        i_address = 32'h0;
        if (f_has) i_address = fq[0].addr;
        d_read = 1'b0; d_write = 1'b0; d_address = 32'h0; d_byteenable = 4'h0; d_writedata = 32'h0;
        if (d_has) begin
            d_read       = !dq[0].wr || dq[0].both;
            d_write      = dq[0].wr;
            d_address    = dq[0].addr;
            d_byteenable = dq[0].be;
            d_writedata  = dq[0].wd;
        end
    endtask

    task automatic reset_model();
        fq.delete(); dq.delete();
        f_has = 0; d_has = 0; f_gap = 0; d_gap = 0;
        active = 0; a_own_d = 0; a_wr = 0; last_d = 1'b1;
        t_arb = 0; a_stall = 0; done_cyc = 0; a_rdata = 0;
        sh_addr = 0; sh_wd = 0; sh_be = 0; sh_grant_d = 0;
        exp_ird = 0; exp_drd = 0;
        drive_ports();
        m_waitrequest = 1'b0;
        m_readdata = 32'h0;
    endtask

    task automatic load_gaps();
        if (!f_has && fq.size() > 0) f_gap = fq[0].gap;
        if (!d_has && dq.size() > 0) d_gap = dq[0].gap;
    endtask

    task automatic chk_reset_vals();
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_m_address", m_address, 0);
        chk("rst_m_byteenable", m_byteenable, 0);
        chk("rst_m_writedata", m_writedata, 0);
        chk("rst_i_waitrequest", i_waitrequest, 1);
        chk("rst_d_waitrequest", d_waitrequest, 1);
        chk("rst_i_readdata", i_readdata, 0);
        chk("rst_d_readdata", d_readdata, 0);
        chk("rst_grant_d", grant_d, 0);
    endtask

    // One clock cycle, evaluated mid-cycle at the falling edge.
    task automatic eng_cycle();
        bit   in_acc, is_done, win_d;
        txn_t t;
        in_acc  = active && (cyc >= t_arb + 1) && (cyc <= t_arb + 1 + a_stall);
        is_done = active && (cyc == done_cyc);

        if (is_done && !a_wr) begin
            if (a_own_d) exp_drd = a_rdata;
            else         exp_ird = a_rdata;
        end
        if (active && cyc == t_arb + 1) dut_win.push_back(grant_d);
        if (i_waitrequest === 1'b0) i_done_obs = cyc;
        if (d_waitrequest === 1'b0) d_done_obs = cyc;
        if (m_read === 1'b1)  mread_seen++;
        if (m_write === 1'b1) mwrite_seen++;

        chk("i_waitrequest", i_waitrequest, !(is_done && !a_own_d));
        chk("d_waitrequest", d_waitrequest, !(is_done && a_own_d));
        chk("i_readdata", i_readdata, exp_ird);
        chk("d_readdata", d_readdata, exp_drd);
        chk("grant_d", grant_d, sh_grant_d);
        chk("m_read", m_read, in_acc && !a_wr);
        chk("m_write", m_write, in_acc && a_wr);
        if (in_acc) begin
            chk("m_address", m_address, sh_addr);
            chk("m_byteenable", m_byteenable, sh_be);
            if (a_wr) chk("m_writedata", m_writedata, sh_wd);
        end

        if (is_done) begin
            $display("TXN %0d port=%s op=%s addr=%08h stall=%0d latency=%0d",
                     ntxn, a_own_d ? "data" : "fetch", a_wr ? "wr" : "rd", sh_addr, a_stall,
                     done_cyc - t_arb);
            ntxn++;
            if (a_own_d) begin
                d_has = 0;
                void'(dq.pop_front());
                if (dq.size() > 0) d_gap = dq[0].gap;
            end else begin
                f_has = 0;
                void'(fq.pop_front());
                if (fq.size() > 0) f_gap = fq[0].gap;
            end
            active = 0;
            free_from = cyc + 1;
        end

        if (!f_has && fq.size() > 0) begin
            if (f_gap == 0) begin f_has = 1; f_raise = cyc; end
            else f_gap--;
        end
        if (!d_has && dq.size() > 0) begin
            if (d_gap == 0) begin d_has = 1; d_raise = cyc; end
            else d_gap--;
        end
        drive_ports();

        if (!active && cyc >= free_from && (f_has || d_has)) begin
            if (f_has && d_has) win_d = RR ? !last_d : 1'b1;
            else                win_d = d_has;
            last_d = win_d;
            if (win_d) t = dq[0];
            else       t = fq[0];
            active     = 1;
            t_arb      = cyc;
            a_own_d    = win_d;
            a_wr       = win_d && t.wr;
            a_stall    = t.stall;
            a_rdata    = t.rdata;
            done_cyc   = cyc + 2 + t.stall + (a_wr ? 0 : 1);
            sh_addr    = t.addr;
            sh_be      = win_d ? t.be : 4'hF;
            sh_wd      = t.wd;
            sh_grant_d = win_d;
        end

        if (in_acc) m_waitrequest = (cyc < t_arb + 1 + a_stall);
        else        m_waitrequest = 1'($urandom_range(0, 1));
        if (active && !a_wr && cyc == t_arb + 2 + a_stall) m_readdata = a_rdata;
        else                                              m_readdata = $urandom;

        step();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fq.size() > 0 || dq.size() > 0 || active) && n < budget) begin
            eng_cycle();
            n++;
        end
        chk("drain_within_budget", n < budget, 1);
        eng_cycle();
        eng_cycle();
    endtask

    initial begin
        int base;
        int n;
        reset = 1'b1;
        reset_model();
        #1 reset = 1'b0;
        // Requests present during reset must not produce a strobe.
        i_read = 1'b1; i_address = 32'hBFC00000;
        d_write = 1'b1; d_address = 32'h100;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk_reset_vals();
            step();
        end
        reset_model();
        reset = 1'b1;
        free_from = cyc;

        // Uncontended fetch
        fq.push_back(mk(0, 0, 0, 32'hBFC00000, 4'hF, 32'h0, 0, 32'h8C020010));
        load_gaps();
        drain(200);
        chk("fetch_latency", i_done_obs - f_raise, 3);
        chk("fetch_readdata", i_readdata, 32'h8C020010);

        // Stalled data write
        dq.push_back(mk(0, 1, 0, 32'hBFC00100, 4'hF, 32'h12112211, 2, 32'h0));
        load_gaps();
        drain(200);
        chk("data_write_latency", d_done_obs - d_raise, 4);

        // Two ties in a row
        base = dut_win.size();
        fq.push_back(mk(0, 0, 0, 32'h00400000, 4'hF, 32'h0, 0, 32'hA1A1A1A1));
        fq.push_back(mk(0, 0, 0, 32'h00400004, 4'hF, 32'h0, 1, 32'hA2A2A2A2));
        dq.push_back(mk(0, 0, 0, 32'h10000000, 4'hF, 32'h0, 0, 32'hD1D1D1D1));
        dq.push_back(mk(0, 0, 0, 32'h10000004, 4'h3, 32'h0, 0, 32'hD2D2D2D2));
        load_gaps();
        drain(300);
        chk("tie_grants_logged", dut_win.size() >= base + 2, 1);
        if (dut_win.size() >= base + 2) begin
            chk("tie1_grant_d", dut_win[base], RR ? 0 : 1);
            chk("tie2_grant_d", dut_win[base + 1], 1);
        end

        // Read+write together, then a write with no lanes enabled
        mread_seen = 0;
        mwrite_seen = 0;
        dq.push_back(mk(0, 1, 1, 32'h20000010, 4'h3, 32'hCAFE0001, 1, 32'h0));
        dq.push_back(mk(0, 1, 0, 32'h20000014, 4'h0, 32'hCAFE0002, 0, 32'h0));
        load_gaps();
        drain(200);
        chk("rw_m_read_cycles", mread_seen, 0);
        chk("rw_m_write_cycles", mwrite_seen, 3);

        // Randomised mixed traffic, starting with the halt fetch at address 0
        fq.push_back(mk(0, 0, 0, 32'h0, 4'hF, 32'h0, 0, $urandom));
        for (int k = 0; k < 30; k++) begin
            int op;
            logic [31:0] a;
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) a = 32'h0;
            fq.push_back(mk($urandom_range(0, 3), 0, 0, a, 4'hF, 32'h0,
                            $urandom_range(0, 3), $urandom));
            op = $urandom_range(0, 5);
            a = $urandom & 32'hFFFF_FFFC;
            dq.push_back(mk($urandom_range(0, 3), op >= 3, op == 5, a, 4'($urandom),
                            $urandom, $urandom_range(0, 3), $urandom));
        end
        load_gaps();
        drain(5000);

        // Reset dropped mid-access aborts the transfer asynchronously
        fq.push_back(mk(0, 0, 0, 32'h00401000, 4'hF, 32'h0, 6, 32'h55AA55AA));
        load_gaps();
        n = 0;
        while (!(active && cyc >= t_arb + 2) && n < 50) begin
            eng_cycle();
            n++;
        end
        chk("abort_reached_access", n < 50, 1);
        chk("abort_pre_m_read", m_read, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_m_read_async", m_read, 0);
        chk("abort_m_address_async", m_address, 0);
        chk("abort_i_waitrequest", i_waitrequest, 1);
        reset_model();
        step();
        reset = 1'b1;
        free_from = cyc;
        for (int k = 0; k < 6; k++) eng_cycle();

        // Recovery after the abort
        fq.push_back(mk(0, 0, 0, 32'hBFC00004, 4'hF, 32'h0, 1, 32'h3C1D0040));
        load_gaps();
        drain(200);
        chk("recover_readdata", i_readdata, 32'h3C1D0040);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
